// File: rtl/sonar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : sonar_scan_controller
// Description : Round-robin scheduler for NUM_CH proximity sensors with
//               per-channel result store, sticky timeouts and optional
//               nearest-object tracker (enable with `define SONAR_NEAREST_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_scan_controller #(
    parameter int NUM_CH         = 4,
    parameter int DIST_W         = 22,
    parameter int SLOT_CYCLES    = 3_125_000,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [NUM_CH-1:0]           sensor_ready,
    input  logic [NUM_CH*DIST_W-1:0]    sensor_dist,
    output logic [NUM_CH-1:0]           measure,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic [NUM_CH*DIST_W-1:0]    dist_out,
    output logic [NUM_CH-1:0]           dist_valid,
    output logic [NUM_CH-1:0]           timeout_err,
    output logic                        frame_done,
    output logic [DIST_W-1:0]           nearest_dist,
    output logic [$clog2(NUM_CH)-1:0]   nearest_ch
);

    localparam int c_CH_W   = $clog2(NUM_CH);
    localparam int c_SLOT_W = $clog2(SLOT_CYCLES + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_SLOT = 3'd1;
    localparam logic [2:0] c_ST_FIRE      = 3'd2;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_ST_STORE     = 3'd5;

    logic [2:0]               r_state;
    logic [c_SLOT_W-1:0]      r_slot_cnt;
    logic [c_TMO_W-1:0]       r_tmo_cnt;
    logic [c_CH_W-1:0]        r_cur_ch;
    logic [NUM_CH-1:0]        r_measure;
    logic [NUM_CH*DIST_W-1:0] r_dist_out;
    logic [NUM_CH-1:0]        r_dist_valid;
    logic [NUM_CH-1:0]        r_timeout_err;
    logic                     r_frame_done;

    logic [c_CH_W-1:0]        w_lowest;
    logic [c_CH_W-1:0]        w_next;
    logic                     w_wrap;
    logic                     w_mask_any;
    logic                     w_cur_ready;
    logic                     w_tmo_hit;
    logic                     w_tmo_evt;
    logic                     w_advance;
    logic [NUM_CH-1:0]        w_cur_onehot;

    assign w_mask_any   = |ch_mask;
    assign w_cur_ready  = sensor_ready[r_cur_ch];
    assign w_tmo_hit    = (r_tmo_cnt >= c_TMO_LAST);
    assign w_cur_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_cur_ch;

    // A result arriving on the same cycle as the timeout wins in WAIT_DONE.
    assign w_tmo_evt = ((r_state == c_ST_WAIT_BUSY) && w_tmo_hit) ||
                       ((r_state == c_ST_WAIT_DONE) && !w_cur_ready && w_tmo_hit);
    assign w_advance = (r_state == c_ST_STORE) || w_tmo_evt;

    // Descending scan: the last hit is the smallest qualifying index.
    always_comb begin
        w_lowest = '0;
        w_next   = '0;
        w_wrap   = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_lowest = c_CH_W'(i);
                if (i > int'(r_cur_ch)) begin
                    w_next = c_CH_W'(i);
                    w_wrap = 1'b0;
                end
            end
        end
        if (w_wrap) begin
            w_next = w_lowest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_slot_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_cur_ch      <= '0;
            r_measure     <= '0;
            r_dist_out    <= '0;
            r_dist_valid  <= '0;
            r_timeout_err <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_measure    <= '0;
            r_frame_done <= 1'b0;

            // Slot counter saturates so pulse spacing is max(slot, measurement).
            if ((r_state != c_ST_IDLE) && (r_slot_cnt != c_SLOT_LAST)) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_slot_cnt <= '0;
                    if (en && w_mask_any) begin
                        r_cur_ch <= w_lowest;
                        r_state  <= c_ST_WAIT_SLOT;
                    end
                end
                c_ST_WAIT_SLOT: begin
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                    end else if ((r_slot_cnt == c_SLOT_LAST) && w_cur_ready) begin
                        r_state    <= c_ST_FIRE;
                        r_slot_cnt <= '0;
                        r_tmo_cnt  <= '0;
                        r_measure  <= w_cur_onehot;
                    end
                end
                c_ST_FIRE: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    r_state   <= c_ST_WAIT_BUSY;
                end
                c_ST_WAIT_BUSY: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (!w_tmo_hit && !w_cur_ready) begin
                        r_state <= c_ST_WAIT_DONE;
                    end
                end
                c_ST_WAIT_DONE: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_cur_ready) begin
                        r_dist_out[int'(r_cur_ch)*DIST_W +: DIST_W] <=
                            sensor_dist[int'(r_cur_ch)*DIST_W +: DIST_W];
                        r_dist_valid[r_cur_ch]  <= 1'b1;
                        r_timeout_err[r_cur_ch] <= 1'b0;
                        r_state                 <= c_ST_STORE;
                    end
                end
                c_ST_STORE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            if (w_tmo_evt) begin
                r_timeout_err[r_cur_ch] <= 1'b1;
                r_dist_valid[r_cur_ch]  <= 1'b0;
            end

            // The mask is only looked at here, so in-flight measurements never abort.
            if (w_advance) begin
                if (w_mask_any) begin
                    r_cur_ch     <= w_next;
                    r_frame_done <= w_wrap;
                end
                r_state <= (en && w_mask_any) ? c_ST_WAIT_SLOT : c_ST_IDLE;
            end
        end
    end

    assign measure     = r_measure;
    assign cur_ch      = r_cur_ch;
    assign dist_out    = r_dist_out;
    assign dist_valid  = r_dist_valid;
    assign timeout_err = r_timeout_err;
    assign frame_done  = r_frame_done;

`ifdef SONAR_NEAREST_EN
    logic [DIST_W-1:0] w_min_dist;
    logic [c_CH_W-1:0] w_min_ch;
    logic              w_found;
    logic [DIST_W-1:0] r_nearest_dist;
    logic [c_CH_W-1:0] r_nearest_ch;

    // Strict less-than keeps ties on the lowest index.
    always_comb begin
        w_min_dist = '1;
        w_min_ch   = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_dist_valid[i] &&
                (!w_found || (r_dist_out[i*DIST_W +: DIST_W] < w_min_dist))) begin
                w_min_dist = r_dist_out[i*DIST_W +: DIST_W];
                w_min_ch   = c_CH_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nearest_dist <= '1;
            r_nearest_ch   <= '0;
        end else begin
            r_nearest_dist <= w_min_dist;
            r_nearest_ch   <= w_min_ch;
        end
    end

    assign nearest_dist = r_nearest_dist;
    assign nearest_ch   = r_nearest_ch;
`else
    assign nearest_dist = '1;
    assign nearest_ch   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sonar_scan_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sonar_scan_controller
// Description : Self-checking bench for sonar_scan_controller with behavioural
//               sensor models and a measure-pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonar_scan_controller;

    localparam int NCH = 4;
    localparam int DW  = 22;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b0;
    logic [NCH-1:0]  ch_mask = '0;
    logic [NCH-1:0]  sens_ready = 4'hF;
    logic [NCH*DW-1:0] sens_dist = '0;
    logic [NCH-1:0]  measure;
    logic [1:0]      cur_ch;
    logic [NCH*DW-1:0] dist_out;
    logic [NCH-1:0]  dist_valid;
    logic [NCH-1:0]  timeout_err;
    logic            frame_done;
    logic [DW-1:0]   nearest_dist;
    logic [1:0]      nearest_ch;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_ch_q[$];
    int frame_q[$];
    int last_pulse = -1;
    int mon_exp;
    logic [NCH-1:0] mon_oh;

    logic [DW-1:0]  sens_val [NCH] = '{default: '0};
    logic [NCH-1:0] never_drop = '0;
    int             busy_cnt [NCH] = '{default: 0};

    typedef struct {
        logic [3:0]       mask;
        logic [3:0]       never;
        logic [NCH*DW-1:0] dvals;
        int               pulses;
        int               frames;
        int               gap;
        logic [3:0]       valid;
        logic [3:0]       tmo;
        logic [NCH*DW-1:0] dout;
        logic [DW-1:0]    ndist;
        logic [1:0]       nch;
    } vec_t;

    vec_t vecs [5];

    sonar_scan_controller #(
        .NUM_CH(NCH), .DIST_W(DW), .SLOT_CYCLES(100), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .sensor_ready(sens_ready), .sensor_dist(sens_dist),
        .measure(measure), .cur_ch(cur_ch), .dist_out(dist_out),
        .dist_valid(dist_valid), .timeout_err(timeout_err),
        .frame_done(frame_done), .nearest_dist(nearest_dist),
        .nearest_ch(nearest_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model: ready drops for 20 cycles after a measure pulse, then the result appears.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (measure[i] && !never_drop[i]) begin
                sens_ready[i] <= 1'b0;
                busy_cnt[i]   <= 20;
            end else if (busy_cnt[i] > 0) begin
                busy_cnt[i] <= busy_cnt[i] - 1;
                if (busy_cnt[i] == 1) begin
                    sens_ready[i]            <= 1'b1;
                    sens_dist[i*DW +: DW]    <= sens_val[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each measure pulse pops the expected channel and checks spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_pulse = -1;
        end else begin
            if (measure != '0) begin
                if (exp_ch_q.size() == 0) begin
                    chk("unexpected_measure", measure, 0);
                end else begin
                    mon_exp = exp_ch_q.pop_front();
                    mon_oh  = 4'b0001 << mon_exp;
                    chk("measure_channel", measure, mon_oh);
                    if (last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, 100);
                end
                last_pulse = cyc;
            end
            if (frame_done) frame_q.push_back(cyc);
        end
    end

    task automatic push_seq(input logic [3:0] m, input int n);
        int c = -1;
        repeat (n) begin
            c = (c + 1) % 4;
            while (!m[c]) c = (c + 1) % 4;
            exp_ch_q.push_back(c);
        end
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        while (exp_ch_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("expected_pulses_pending", exp_ch_q.size(), 0);
        exp_ch_q.delete();
    endtask

    task automatic wait_meas(input int ch, input int budget, output int t);
        int n = 0;
        t = -1;
        while (n < budget) begin
            @(negedge clk);
            if (measure[ch]) begin
                t = cyc;
                break;
            end
            n++;
        end
        chk("measure_seen", (t >= 0), 1'b1);
    endtask

    task automatic start_run(input logic [3:0] m, input logic [3:0] nd,
                             input logic [NCH*DW-1:0] vals);
        en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        never_drop = nd;
        for (int i = 0; i < NCH; i++) sens_val[i] = vals[i*DW +: DW];
        exp_ch_q.delete();
        frame_q.delete();
        rst_n = 1'b1;
        ch_mask = m;
        en = 1'b1;
    endtask

    task automatic chk_nearest(input string name, input logic [DW-1:0] d, input logic [1:0] c);
`ifdef SONAR_NEAREST_EN
        chk({name, "_dist"}, nearest_dist, d);
        chk({name, "_ch"}, nearest_ch, c);
`else
        chk({name, "_dist"}, nearest_dist, {DW{1'b1}});
        chk({name, "_ch"}, nearest_ch, 2'd0);
`endif
    endtask

    initial begin
        int tp, tt, rel;
        vecs[0] = '{mask:4'hF, never:4'h0, dvals:{22'd40, 22'd30, 22'd20, 22'd10}, pulses:8, frames:2, gap:400,
                    valid:4'hF, tmo:4'h0, dout:{22'd40, 22'd30, 22'd20, 22'd10}, ndist:22'd10, nch:2'd0};
        vecs[1] = '{mask:4'b1010, never:4'h0, dvals:{22'd40, 22'd30, 22'd20, 22'd10}, pulses:4, frames:2, gap:200,
                    valid:4'b1010, tmo:4'h0, dout:{22'd40, 22'd0, 22'd20, 22'd0}, ndist:22'd20, nch:2'd1};
        vecs[2] = '{mask:4'hF, never:4'h0, dvals:{22'd90, 22'd5, 22'd5, 22'd40}, pulses:4, frames:1, gap:0,
                    valid:4'hF, tmo:4'h0, dout:{22'd90, 22'd5, 22'd5, 22'd40}, ndist:22'd5, nch:2'd1};
        vecs[3] = '{mask:4'hF, never:4'b0100, dvals:{22'd40, 22'd30, 22'd20, 22'd10}, pulses:4, frames:1, gap:0,
                    valid:4'b1011, tmo:4'b0100, dout:{22'd40, 22'd0, 22'd20, 22'd10}, ndist:22'd10, nch:2'd0};
        vecs[4] = '{mask:4'b0100, never:4'h0, dvals:{22'd7, 22'd0, 22'd9, 22'd3}, pulses:2, frames:2, gap:100,
                    valid:4'b0100, tmo:4'h0, dout:{NCH*DW{1'b0}}, ndist:22'd0, nch:2'd2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_measure", measure, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_dist_out", dist_out, 0);
        chk("rst_dist_valid", dist_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_nearest_dist", nearest_dist, {DW{1'b1}});
        chk("rst_nearest_ch", nearest_ch, 0);

        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v].mask, vecs[v].never, vecs[v].dvals);
            push_seq(vecs[v].mask, vecs[v].pulses);
            wait_q(vecs[v].pulses * 100 + 300);
            en = 1'b0;
            repeat (150) @(negedge clk);
            chk($sformatf("v%0d_dist_out", v), dist_out, vecs[v].dout);
            chk($sformatf("v%0d_dist_valid", v), dist_valid, vecs[v].valid);
            chk($sformatf("v%0d_timeout_err", v), timeout_err, vecs[v].tmo);
            chk($sformatf("v%0d_idle_measure", v), measure, 0);
            chk($sformatf("v%0d_frames", v), frame_q.size(), vecs[v].frames);
            if (vecs[v].gap != 0 && frame_q.size() >= 2)
                chk($sformatf("v%0d_frame_gap", v), frame_q[1] - frame_q[0], vecs[v].gap);
            chk_nearest($sformatf("v%0d_nearest", v), vecs[v].ndist, vecs[v].nch);
        end

        // Timeout on channel 2, then a good result clears the flag
        start_run(4'hF, 4'b0100, {22'd40, 22'd30, 22'd20, 22'd10});
        push_seq(4'hF, 4);
        wait_meas(2, 600, tp);
        tt = -1;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (timeout_err[2]) begin
                tt = cyc;
                break;
            end
        end
        chk("tmo_latency", tt - tp, 50);
        chk("tmo_valid2", dist_valid[2], 1'b0);
        chk("tmo_advance_ch", cur_ch, 2'd3);
        never_drop = '0;
        exp_ch_q.push_back(0);
        exp_ch_q.push_back(1);
        exp_ch_q.push_back(2);
        wait_q(600);
        en = 1'b0;
        repeat (150) @(negedge clk);
        chk("recover_timeout_err", timeout_err, 0);
        chk("recover_dist_valid", dist_valid, 4'hF);
        chk("recover_dist2", dist_out[2*DW +: DW], 22'd30);

        // Asynchronous reset during WAIT_DONE of channel 1
        start_run(4'hF, 4'h0, {22'd40, 22'd30, 22'd20, 22'd10});
        push_seq(4'hF, 2);
        wait_meas(1, 400, tp);
        repeat (10) @(negedge clk);
        chk("pre_rst_valid", dist_valid, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_measure", measure, 0);
        chk("arst_cur_ch", cur_ch, 0);
        chk("arst_dist_out", dist_out, 0);
        chk("arst_dist_valid", dist_valid, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_nearest_dist", nearest_dist, {DW{1'b1}});
        repeat (2) @(negedge clk);
        exp_ch_q.delete();
        exp_ch_q.push_back(0);
        rst_n = 1'b1;
        rel = cyc;
        wait_meas(0, 300, tp);
        chk("post_rst_delay_ok", (tp - rel >= 100) && (tp - rel <= 102), 1'b1);
        en = 1'b0;
        repeat (150) @(negedge clk);

        // en dropped while channel 2 is measuring
        start_run(4'hF, 4'h0, {22'd90, 22'd5, 22'd5, 22'd40});
        push_seq(4'hF, 3);
        wait_meas(2, 600, tp);
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (250) @(negedge clk);
        chk("endrop_dist_valid", dist_valid, 4'b0111);
        chk("endrop_dist2", dist_out[2*DW +: DW], 22'd5);
        chk("endrop_idle_measure", measure, 0);
        chk("endrop_pending", exp_ch_q.size(), 0);
        chk_nearest("endrop_nearest", 22'd5, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
